// File: rtl/data_mem_responder_if.sv
// Request/response bundle for the MEMORY-stage data SRAM port.
// The master drives requests; the slave (data memory responder) returns read data and status.
interface data_mem_responder_if #(
   parameter int MEM_ADDR_SIZE = 10,
   parameter int MEM_DATA_SIZE = 32
);
   logic                     MEM_csb0;
   logic                     MEM_web0;
   logic [MEM_ADDR_SIZE-1:0] MEM_addr0;
   logic [MEM_DATA_SIZE-1:0] MEM_din0;
   logic [MEM_DATA_SIZE-1:0] MEM_dout0;
   logic                     MEM_dout_valid;
   logic                     MEM_ready;
   logic                     MEM_err;

   modport master (
      output MEM_csb0, MEM_web0, MEM_addr0, MEM_din0,
      input  MEM_dout0, MEM_dout_valid, MEM_ready, MEM_err
   );

   modport slave (
      input  MEM_csb0, MEM_web0, MEM_addr0, MEM_din0,
      output MEM_dout0, MEM_dout_valid, MEM_ready, MEM_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: word array cleared after reset by a walk FSM, fixed-latency
// pipelined reads, out-of-range detection with a one-cycle error pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | walking cnt over 0..MEM_DEPTH-1 writing zero; requests ignored
// S_READY | MEM_ready=1, requests accepted (terminal, left only by reset)
module data_mem_responder #(
   parameter int MEM_ADDR_SIZE = 10,
   parameter int MEM_DATA_SIZE = 32,
   parameter int MEM_DEPTH     = 512,
   parameter int READ_LAT      = 1
) (
   input logic CLK,
   input logic RSTn,
   data_mem_responder_if.slave mem
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int CNT_W = $clog2(MEM_DEPTH + 1);
   localparam logic [MEM_ADDR_SIZE:0] DEPTH_EXT = (MEM_ADDR_SIZE + 1)'(MEM_DEPTH);
   localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(MEM_DEPTH - 1);

   if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
      $error("data_mem_responder: READ_LAT must be in 1..4");
   end
   if (MEM_DEPTH < 2 || MEM_DEPTH > (1 << MEM_ADDR_SIZE)) begin : g_bad_depth
      $error("data_mem_responder: MEM_DEPTH must be in 2..2**MEM_ADDR_SIZE");
   end

   typedef enum logic {
      S_CLEAR,
      S_READY
   } state_t;

   state_t                   state;
   logic [CNT_W-1:0]         cnt;
   logic                     ready_q;
   logic                     err_q;

   logic [MEM_DATA_SIZE-1:0] mem_array [MEM_DEPTH];

   logic [READ_LAT-1:0]      pipe_vld;
   logic [MEM_DATA_SIZE-1:0] pipe_dat [READ_LAT];

   logic                     req_acc;
   logic                     in_range;
   logic                     wr_acc;
   logic                     rd_acc;
   logic [IDX_W-1:0]         req_idx;
   logic [IDX_W-1:0]         clr_idx;
   logic [MEM_DATA_SIZE-1:0] rd_word;

   // Full-width unsigned compare so addresses just past the array never alias onto it.
   assign in_range = {1'b0, mem.MEM_addr0} < DEPTH_EXT;
   assign req_acc  = ready_q & ~mem.MEM_csb0;
   assign wr_acc   = req_acc & ~mem.MEM_web0 & in_range;
   assign rd_acc   = req_acc & mem.MEM_web0;
   assign req_idx  = mem.MEM_addr0[IDX_W-1:0];
   assign clr_idx  = cnt[IDX_W-1:0];
   assign rd_word  = in_range ? mem_array[req_idx] : '0;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state   <= S_CLEAR;
         cnt     <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state)
            S_CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state   <= S_READY;
                  ready_q <= 1'b1;
               end
            end
            S_READY: begin
               ready_q <= 1'b1;
            end
            default: begin
               state   <= S_CLEAR;
               cnt     <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // No reset on the array: contents are undefined until the clear walk completes.
   always_ff @(posedge CLK) begin
      if (state == S_CLEAR) begin
         mem_array[clr_idx] <= '0;
      end else if (wr_acc) begin
         mem_array[req_idx] <= mem.MEM_din0;
      end
   end

   // Each stage only loads when a valid word arrives, so the last stage holds between pulses.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         pipe_vld <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < READ_LAT; i++) begin
            pipe_dat[i] <= '0;
         end
      end else begin
         err_q       <= req_acc & ~in_range;
         pipe_vld[0] <= rd_acc;
         if (rd_acc) begin
            pipe_dat[0] <= rd_word;
         end
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            if (pipe_vld[i-1]) begin
               pipe_dat[i] <= pipe_dat[i-1];
            end
         end
      end
   end

   assign mem.MEM_dout0      = pipe_dat[READ_LAT-1];
   assign mem.MEM_dout_valid = pipe_vld[READ_LAT-1];
   assign mem.MEM_ready      = ready_q;
   assign mem.MEM_err        = err_q;

endmodule
